// File: rtl/ram_block_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ block requesters.
// Each grant runs one atomic BLOCK_WORDS burst with ERROR retry and wait timeout.
module ram_block_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NREQ-1:0]            i_req_valid,
  input  logic [NREQ-1:0]            i_req_wen,
  input  logic [NREQ*32-1:0]         i_req_addr,
  input  logic [NREQ*32-1:0]         i_req_wdata,
  output logic [NREQ-1:0]            o_grant,
  output logic [((BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1)-1:0] o_word_idx,
  output logic [NREQ-1:0]            o_word_ack,
  output logic [31:0]                o_rdata,
  output logic [NREQ-1:0]            o_req_done,
  output logic [NREQ-1:0]            o_req_err,
  output logic                       o_ram_ren,
  output logic                       o_ram_wen,
  output logic [31:0]                o_ram_addr,
  output logic [31:0]                o_ram_store,
  input  logic [31:0]                i_ram_load,
  input  logic [1:0]                 i_ram_state
);

  localparam int unsigned IDX_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned OWN_W  = $clog2(NREQ);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RETRY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [NREQ-1:0]   ONE_HOT0  = NREQ'(1);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_t;

  state_t             r_state, w_state_next;
  logic [NREQ-1:0]    r_grant, w_grant_next;
  logic [OWN_W-1:0]   r_owner, w_owner_next;
  logic [OWN_W-1:0]   r_last, w_last_next;
  logic [31:0]        r_base, w_base_next;
  logic               r_wen, w_wen_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic [WAIT_W-1:0]  r_wait, w_wait_next;
  logic [RTY_W-1:0]   r_retry, w_retry_next;
  logic               r_fin, w_fin_next;

  logic               w_pick_found;
  logic [OWN_W-1:0]   w_pick;
  int unsigned        w_cand;
  logic               w_own_valid;
  logic               w_last_word;
  logic               w_access;
  logic               w_drop;
  logic               w_retry_abort;

  // Scan starts just past the previous owner so every pending requester gets a turn.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_cand       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = (32'(r_last) + k) % NREQ;
      if (!w_pick_found && i_req_valid[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick       = OWN_W'(w_cand);
      end
    end
  end

  assign w_own_valid   = i_req_valid[r_owner];
  assign w_last_word   = (r_idx == LAST_IDX);
  assign w_access      = (i_ram_state == RAM_ACCESS);
  assign w_retry_abort = (r_retry == RETRY_LIM);
  // A requester dropping out loses the burst unless its final word completes this cycle.
  assign w_drop        = !w_own_valid && !(w_access && w_last_word && !w_retry_abort);

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_base_next  = r_base;
    w_wen_next   = r_wen;
    w_idx_next   = r_idx;
    w_wait_next  = r_wait;
    w_retry_next = r_retry;
    w_fin_next   = r_fin;
    o_word_ack   = '0;
    o_rdata      = '0;
    o_req_done   = '0;
    o_req_err    = '0;
    o_ram_ren    = 1'b0;
    o_ram_wen    = 1'b0;
    o_ram_addr   = '0;
    o_ram_store  = '0;

    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_state_next = StXfer;
          w_grant_next = ONE_HOT0 << w_pick;
          w_owner_next = w_pick;
          w_base_next  = i_req_addr[w_pick*32 +: 32];
          w_wen_next   = i_req_wen[w_pick];
          w_idx_next   = '0;
          w_wait_next  = '0;
          w_retry_next = '0;
          w_fin_next   = 1'b0;
        end
      end

      StXfer: begin
        o_ram_addr  = r_base + 32'({r_idx, 2'b00});
        o_ram_store = i_req_wdata[r_owner*32 +: 32];
        if (w_drop) begin
          w_state_next = StDone;
          w_grant_next = '0;
        end else if (w_retry_abort) begin
          o_req_err    = r_grant;
          w_state_next = StDone;
          w_grant_next = '0;
        end else begin
          o_ram_ren = ~r_wen;
          o_ram_wen = r_wen;
          unique case (i_ram_state)
            RAM_ACCESS: begin
              o_word_ack   = r_grant;
              o_rdata      = i_ram_load;
              w_wait_next  = '0;
              w_retry_next = '0;
              if (w_last_word) begin
                w_fin_next   = 1'b1;
                w_state_next = StDone;
                w_grant_next = '0;
                w_idx_next   = '0;
              end else begin
                w_idx_next = r_idx + 1'b1;
              end
            end
            RAM_ERROR: begin
              w_retry_next = r_retry + 1'b1;
            end
            RAM_FREE, RAM_BUSY: begin
              if (r_wait == WAIT_LIM) begin
                o_req_err    = r_grant;
                w_state_next = StDone;
                w_grant_next = '0;
              end else begin
                w_wait_next = r_wait + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      StDone: begin
        // Completion is reported here so it never coincides with the last word_ack.
        if (r_fin) begin
          o_req_done = ONE_HOT0 << r_owner;
        end
        w_last_next  = r_owner;
        w_fin_next   = 1'b0;
        w_idx_next   = '0;
        w_state_next = StIdle;
      end

      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= OWN_W'(NREQ - 1);
      r_base  <= '0;
      r_wen   <= 1'b0;
      r_idx   <= '0;
      r_wait  <= '0;
      r_retry <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_base  <= w_base_next;
      r_wen   <= w_wen_next;
      r_idx   <= w_idx_next;
      r_wait  <= w_wait_next;
      r_retry <= w_retry_next;
      r_fin   <= w_fin_next;
    end
  end

  assign o_grant    = r_grant;
  assign o_word_idx = r_idx;

endmodule

// File: tb/tb_ram_block_arbiter.sv
// Scoreboard bench for ram_block_arbiter: directed bursts against a small RAM/requester model.
module tb_ram_block_arbiter;
  localparam int NREQ = 2;
  localparam int BW   = 2;
  localparam int TO   = 64;
  localparam int MR   = 3;

  localparam logic [1:0] RS_FREE = 2'd0;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;

  // Scoreboard event kinds
  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wen;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   grant;
  logic [0:0]        word_idx;
  logic [NREQ-1:0]   word_ack;
  logic [31:0]       rdata;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic              ram_ren;
  logic              ram_wen;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_store;
  logic [31:0]       ram_load;
  logic [1:0]        ram_state;

  ram_block_arbiter #(
    .NREQ(NREQ), .BLOCK_WORDS(BW), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_grant(grant), .o_word_idx(word_idx), .o_word_ack(word_ack), .o_rdata(rdata),
    .o_req_done(req_done), .o_req_err(req_err),
    .o_ram_ren(ram_ren), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr),
    .o_ram_store(ram_store), .i_ram_load(ram_load), .i_ram_state(ram_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        en;
  } exp_t;

  exp_t             sbq[$];
  logic [NREQ-1:0]  glog[$];
  int               n_chk  = 0;
  int               n_fail = 0;
  int               mode   = 0;  // 0: ACCESS after lat BUSY, 1: ERROR always, 2: BUSY always
  int               lat    = 0;
  int               cnt    = 0;
  logic [31:0]      wpat [NREQ] = '{32'h0, 32'h0};

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int req, input logic [31:0] addr,
                      input logic [31:0] data, input logic en);
    exp_t e;
    e.kind = kind; e.req = req; e.addr = addr; e.data = data; e.en = en;
    sbq.push_back(e);
  endtask

  // RAM and requester write-data model, updated just after each rising edge.
  initial begin
    ram_state = RS_FREE;
    ram_load  = '0;
    req_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) req_wdata[r*32 +: 32] = wpat[r] + 32'(word_idx);
      if (!(ram_ren || ram_wen)) begin
        ram_state = RS_FREE;
        cnt       = 0;
      end else if (mode == 1) begin
        ram_state = RS_ERR;
      end else if (mode == 2) begin
        ram_state = RS_BUSY;
      end else if (cnt >= lat) begin
        ram_state = RS_ACC;
        cnt       = 0;
      end else begin
        ram_state = RS_BUSY;
        cnt++;
      end
      ram_load = rd_model(ram_addr);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses ack/done/err.
  initial begin
    exp_t            e;
    int              nev;
    int              akind;
    int              areq;
    logic [NREQ-1:0] prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (grant != prev_grant && grant != '0) glog.push_back(grant);
        prev_grant = grant;
        if (ram_ren && ram_wen) begin
          n_chk++; n_fail++;
          $display("FAIL one_enable: ren=%b wen=%b, expected at most one", ram_ren, ram_wen);
        end
        nev = $countones({word_ack, req_done, req_err});
        if (nev > 1) begin
          n_chk++; n_fail++;
          $display("FAIL exclusive_pulses: ack=%b done=%b err=%b, expected one", word_ack,
                   req_done, req_err);
        end
        if (nev != 0) begin
          if (|word_ack) begin
            akind = ram_wen ? K_WR : K_RD;
            areq  = oh2i(word_ack);
          end else if (|req_done) begin
            akind = K_DONE;
            areq  = oh2i(req_done);
          end else begin
            akind = K_ERR;
            areq  = oh2i(req_err);
          end
          if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: got kind %0d req %0d, expected none", akind, areq);
          end else begin
            e = sbq.pop_front();
            chk("ev_kind", 32'(akind), 32'(e.kind));
            chk("ev_req", 32'(areq), 32'(e.req));
            if (e.kind == K_RD) begin
              chk("rd_addr", ram_addr, e.addr);
              chk("rdata", rdata, e.data);
            end else if (e.kind == K_WR) begin
              chk("wr_addr", ram_addr, e.addr);
              chk("ram_store", ram_store, e.data);
              chk("ren_in_write", 32'(ram_ren), 32'(0));
            end else if (e.kind == K_ERR) begin
              chk("err_enable", 32'(ram_ren | ram_wen), 32'(e.en));
            end
          end
        end
      end
    end
  end

  task automatic start(input int r, input logic wen, input logic [31:0] addr);
    @(negedge clk);
    req_wen[r]            = wen;
    req_addr[r*32 +: 32]  = addr;
    req_valid[r]          = 1'b1;
  endtask

  // Wait for requester r's done/err pulse, then release its request.
  task automatic wait_end(input int r, input int maxc);
    logic seen = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (req_done[r] || req_err[r]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("burst_end_seen", 32'(seen), 32'(1));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int             ndone;
    int             c;
    logic           seen;
    logic [NREQ-1:0] gexp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst       = 1'b1;
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_enables", 32'({ram_ren, ram_wen}), 32'(0));
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_pulses", 32'({word_ack, req_done, req_err}), 32'(0));
    chk("rst_rdata_idx", rdata | 32'(word_idx), 32'h0);
    rst = 1'b0;

    // 1: single read, two BUSY before each ACCESS
    lat = 2;
    push(K_RD, 0, 32'h100, rd_model(32'h100), 1'b0);
    push(K_RD, 0, 32'h104, rd_model(32'h104), 1'b0);
    push(K_DONE, 0, 32'h0, 32'h0, 1'b0);
    start(0, 1'b0, 32'h100);
    @(negedge clk);
    chk("t1_grant_latency", 32'(grant), 32'(2'b01));
    wait_end(0, 40);
    @(negedge clk);
    chk("t1_grant_after_done", 32'(grant), 32'(0));

    // 2: both requesting continuously from reset -> strict alternation
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    glog.delete();
    lat = 0;
    for (int b = 0; b < 4; b++) begin
      logic [31:0] base;
      base = (b % 2 == 1) ? 32'h400 : 32'h300;
      push(K_RD, b % 2, base, rd_model(base), 1'b0);
      push(K_RD, b % 2, base + 32'h4, rd_model(base + 32'h4), 1'b0);
      push(K_DONE, b % 2, 32'h0, 32'h0, 1'b0);
    end
    req_wen  = '0;
    req_addr = {32'h400, 32'h300};
    req_valid = 2'b11;
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ndone += $countones(req_done);
      if (ndone >= 4) break;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("t2_done_count", 32'(ndone), 32'(4));
    chk("t2_grant_count", 32'(glog.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk("t2_grant_order", 32'(glog[i]), 32'(gexp[i]));
    end

    // 3: write burst, store data follows word_idx
    lat     = 1;
    wpat[0] = 32'hAAAA_0000;
    push(K_WR, 0, 32'h200, 32'hAAAA_0000, 1'b0);
    push(K_WR, 0, 32'h204, 32'hAAAA_0001, 1'b0);
    push(K_DONE, 0, 32'h0, 32'h0, 1'b0);
    start(0, 1'b1, 32'h200);
    wait_end(0, 40);

    // 4: three ERRORs on word 0 -> abort with enables low, no ack
    mode = 1;
    push(K_ERR, 0, 32'h0, 32'h0, 1'b0);
    start(0, 1'b0, 32'h500);
    wait_end(0, 40);
    mode = 0;
    @(negedge clk);
    chk("t4_idle_grant", 32'(grant), 32'(0));

    // 5: BUSY forever on req 1 -> timeout err in its TO-th XFER cycle, then req 0 served
    mode = 2;
    lat  = 1;
    push(K_ERR, 1, 32'h0, 32'h0, 1'b1);
    push(K_RD, 0, 32'h700, rd_model(32'h700), 1'b0);
    push(K_RD, 0, 32'h704, rd_model(32'h704), 1'b0);
    push(K_DONE, 0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    req_wen   = '0;
    req_addr  = {32'h600, 32'h700};
    req_valid = 2'b11;
    c = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (grant[1]) c++;
      if (req_err[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_err_seen", 32'(seen), 32'(1));
    chk("t5_timeout_cycles", 32'(c), 32'(TO));
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    mode = 0;
    wait_end(0, 40);

    // 6: address wrap, then reset in the middle of a burst
    lat = 0;
    push(K_RD, 0, 32'hFFFF_FFFC, rd_model(32'hFFFF_FFFC), 1'b0);
    push(K_RD, 0, 32'h0000_0000, rd_model(32'h0000_0000), 1'b0);
    push(K_DONE, 0, 32'h0, 32'h0, 1'b0);
    start(0, 1'b0, 32'hFFFF_FFFC);
    wait_end(0, 20);
    mode = 2;
    start(1, 1'b0, 32'h800);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_burst_started", 32'(seen), 32'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'(0));
    chk("t6_rst_enables", 32'({ram_ren, ram_wen}), 32'(0));
    chk("t6_rst_addr", ram_addr | 32'(word_idx), 32'h0);
    @(posedge clk);
    #1;
    chk("t6_rst_held", 32'({grant, word_ack, req_done, req_err}), 32'(0));
    req_valid = '0;
    mode = 0;
    @(negedge clk);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
